// File: rtl/nn_pkg.sv
// Shared constants and types for the layer-1 neuron helpers (Q3.4 fixed point).
package nn_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAC_BITS = 4;
  localparam int unsigned ONE       = 16;
  localparam int unsigned HALF      = 8;

  // PLAN sigmoid breakpoints on |x| and per-segment offsets (valid for FRAC_BITS = 4)
  localparam int unsigned PLAN_BP0  = 16;
  localparam int unsigned PLAN_BP1  = 38;
  localparam int unsigned PLAN_BP2  = 80;
  localparam int unsigned PLAN_OFF0 = 8;
  localparam int unsigned PLAN_OFF1 = 10;
  localparam int unsigned PLAN_OFF2 = 432;

  typedef logic signed [DATA_W-1:0] fx_t;

endpackage

// File: rtl/nn_plan_sigmoid.sv
// Piecewise-linear sigmoid approximation (PLAN), purely combinational z -> a.
module nn_plan_sigmoid import nn_pkg::*; #(
  parameter int unsigned DataW    = DATA_W,
  parameter int unsigned FracBits = FRAC_BITS
) (
  input  logic signed [DataW-1:0] z_i,
  output logic signed [DataW-1:0] a_o
);

  // One extra bit so that |-2^(DataW-1)| is representable
  localparam int unsigned UW = DataW + 1;
  localparam logic [UW-1:0] One = UW'(1 << FracBits);

  logic          neg;
  logic [UW-1:0] u;
  logic [UW-1:0] f;
  logic [UW:0]   mid_sum;

  // Fold to |x|, evaluate the positive half of the curve, mirror for negative inputs
  always_comb begin
    neg     = z_i[DataW-1];
    u       = neg ? (UW'(0) - {z_i[DataW-1], z_i}) : {1'b0, z_i};
    mid_sum = {1'b0, u} + (UW + 1)'(PLAN_OFF2);
    if (u < UW'(PLAN_BP0)) begin
      f = (u >> 2) + UW'(PLAN_OFF0);
    end else if (u < UW'(PLAN_BP1)) begin
      f = (u >> 3) + UW'(PLAN_OFF1);
    end else if (u < UW'(PLAN_BP2)) begin
      f = UW'(mid_sum >> 5);
    end else begin
      f = One;
    end
    a_o = DataW'(neg ? (One - f) : f);
  end

endmodule

// File: rtl/nn_layer1_mac_counter_act.sv
// Layer-1 neuron helper: counts MAC-step acks into a sticky done flag and
// maps the pre-activation to its activation through the PLAN sigmoid.
module nn_layer1_mac_counter_act #(
  parameter int unsigned N_INPUTS  = 2,
  parameter int unsigned DATA_W    = nn_pkg::DATA_W,
  parameter int unsigned FRAC_BITS = nn_pkg::FRAC_BITS,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ack,
  output logic                     ack_mac,
  input  logic signed [DATA_W-1:0] z_value,
  output logic signed [DATA_W-1:0] a
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_INPUTS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_mac_q, ack_mac_d;

  // Count acks until the last one; then freeze (no wrap) until reset
  always_comb begin
    cnt_d     = cnt_q;
    ack_mac_d = ack_mac_q;
    if (!ack_mac_q && ack) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LastCnt) begin
        ack_mac_d = 1'b1;
      end
    end
  end

  // Counter state, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ack_mac_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ack_mac_q <= ack_mac_d;
    end
  end

  assign ack_mac = ack_mac_q;

  nn_plan_sigmoid #(
    .DataW    (DATA_W),
    .FracBits (FRAC_BITS)
  ) u_plan (
    .z_i (z_value),
    .a_o (a)
  );

endmodule

// File: tb/tb_nn_layer1_mac_counter_act.sv
// Directed bench for the layer-1 MAC counter and PLAN sigmoid.
module tb_nn_layer1_mac_counter_act;

  logic              clk = 1'b0;
  logic              rst;
  logic              ack;
  logic              ack_mac;
  logic signed [7:0] z_value;
  logic signed [7:0] a;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int z;
    int a_exp;
  } vec_t;

  vec_t vecs[10];
  int   a_seen[256];

  nn_layer1_mac_counter_act dut (
    .clk     (clk),
    .rst     (rst),
    .ack     (ack),
    .ack_mac (ack_mac),
    .z_value (z_value),
    .a       (a)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent reference of the activation curve using integer division
  function automatic int model_a(input int z);
    int u, f;
    u = (z < 0) ? -z : z;
    if (u < 16)      f = u / 4 + 8;
    else if (u < 38) f = u / 8 + 10;
    else if (u < 80) f = (u + 432) / 32;
    else             f = 16;
    return (z < 0) ? 16 - f : f;
  endfunction

  // One-cycle ack pulse driven at negedge, spanning exactly one posedge
  task automatic pulse();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{z: 0,    a_exp: 8};
    vecs[1] = '{z: 8,    a_exp: 10};
    vecs[2] = '{z: 16,   a_exp: 12};
    vecs[3] = '{z: 40,   a_exp: 14};
    vecs[4] = '{z: 80,   a_exp: 16};
    vecs[5] = '{z: 127,  a_exp: 16};
    vecs[6] = '{z: -16,  a_exp: 4};
    vecs[7] = '{z: -40,  a_exp: 2};
    vecs[8] = '{z: -128, a_exp: 0};
    vecs[9] = '{z: -1,   a_exp: 8};

    rst     = 1'b1;
    ack     = 1'b0;
    z_value = '0;
    #1;
    check("reset_ack_mac", int'(ack_mac), 0);
    idle(2);
    rst = 1'b0;

    // Two pulses complete a run; a third is ignored
    pulse();
    check("after_pulse1", int'(ack_mac), 0);
    idle(1);
    pulse();
    check("after_pulse2", int'(ack_mac), 1);
    pulse();
    check("after_pulse3_sticky", int'(ack_mac), 1);
    idle(3);
    check("sticky_idle", int'(ack_mac), 1);

    // Asynchronous reset between edges clears before the next posedge
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_clear", int'(ack_mac), 0);
    #1 rst = 1'b0;
    pulse();
    check("rerun_pulse1", int'(ack_mac), 0);
    pulse();
    check("rerun_pulse2", int'(ack_mac), 1);

    // Pulse, reset, pulse: count restarts so not done
    sync_reset();
    pulse();
    sync_reset();
    pulse();
    check("restart_after_rst", int'(ack_mac), 0);
    pulse();
    check("restart_complete", int'(ack_mac), 1);

    // rst held across an edge together with ack: ack is not counted
    sync_reset();
    pulse();
    @(negedge clk) begin rst = 1'b1; ack = 1'b1; end
    @(negedge clk) begin rst = 1'b0; ack = 1'b0; end
    pulse();
    check("rst_dominates_ack", int'(ack_mac), 0);
    pulse();
    check("rst_dominates_done", int'(ack_mac), 1);

    // Directed activation points
    for (int i = 0; i < 10; i++) begin
      z_value = 8'(vecs[i].z);
      #1;
      check($sformatf("act_z=%0d", vecs[i].z), int'(a), vecs[i].a_exp);
    end

    // Breakpoint continuity on the positive side
    z_value = 8'sd15; #1; check("bp_z15", int'(a), 11);
    z_value = 8'sd38; #1; check("bp_z38", int'(a), 14);
    z_value = 8'sd79; #1; check("bp_z79", int'(a), 15);

    // Exhaustive sweep against the reference model and range
    for (int z = -128; z <= 127; z++) begin
      z_value = 8'(z);
      #1;
      a_seen[z + 128] = int'(a);
      check($sformatf("sweep_z=%0d", z), int'(a), model_a(z));
      check($sformatf("range_z=%0d", z), int'((a >= 0) && (a <= 16)), 1);
    end
    for (int z = -127; z <= 127; z++) begin
      check($sformatf("monotonic_z=%0d", z),
            int'(a_seen[z + 128] >= a_seen[z + 127]), 1);
      check($sformatf("symmetry_z=%0d", z), a_seen[z + 128] + a_seen[128 - z], 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
